axis_lrelu_frame_builder: RTL and testbench

- Transmit-side framer that produces the combined stream the LReLU engine consumes.
- Per layer it emits a config header, then forwards conv-core output beats until the layer's tlast.
  - Header: 20 beats for 3x3, 9 beats for 1x1.
- It merges a config source and the conv data source into one AXI-Stream, with tuser/tlast formatted for the engine's slave port.
- It sits between the conv core / config DMA and the LReLU engine.

---
 rtl/axis_lrelu_frame_builder_if.sv | 20 ++
 rtl/axis_lrelu_frame_builder.sv | 142 ++++++++++++++
 tb/tb_axis_lrelu_frame_builder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_lrelu_frame_builder_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_lrelu_frame_builder_if
// Brief    : AXI-Stream bundle (valid/ready/data/user/last) for the LReLU framer
// Revision : 1.0 - initial release
// ============================================================================
interface axis_lrelu_frame_builder_if #(
   parameter int DATA_W = 2048,
   parameter int USER_W = 1
) ();
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [USER_W-1:0] tuser;
   logic              tlast;

   modport master (output tvalid, tdata, tuser, tlast, input tready);
   modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_lrelu_frame_builder.sv
`default_nettype none
// ============================================================================
// Module   : axis_lrelu_frame_builder
// Brief    : Merges config headers and conv-core data into the LReLU stream
// Revision : 1.0 - initial release
// ============================================================================
module axis_lrelu_frame_builder #(
   parameter int WORD_WIDTH_IN      = 32,
   parameter int UNITS              = 8,
   parameter int GROUPS             = 2,
   parameter int COPIES             = 2,
   parameter int MEMBERS            = 2,
   parameter int CONFIG_BEATS_3X3_1 = 19,
   parameter int CONFIG_BEATS_1X1_1 = 8,
   parameter int BITS_CONV_CORE     = $clog2(GROUPS*COPIES*MEMBERS),
   parameter int I_IS_3X3           = BITS_CONV_CORE + 0,
   parameter int TUSER_WIDTH_LRELU  = BITS_CONV_CORE + 8,
   parameter int DATA_W             = MEMBERS*COPIES*GROUPS*UNITS*WORD_WIDTH_IN
) (
   input  wire                        aclk,
   input  wire                        aresetn,
   axis_lrelu_frame_builder_if.slave  s_cfg,   // tuser[0] carries is_3x3
   axis_lrelu_frame_builder_if.slave  s_data,
   axis_lrelu_frame_builder_if.master m_axis,
   output logic                       cfg_err
);
   localparam int c_cnt_w  = $clog2(CONFIG_BEATS_3X3_1 + 1);
   localparam int c_beat_w = DATA_W + TUSER_WIDTH_LRELU + 1;
   localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);
   // The CFG_1_S beat is one of the header beats, so CFG_2_S runs count..0.
   localparam logic [c_cnt_w-1:0] c_load_3x3 = c_cnt_w'(CONFIG_BEATS_3X3_1 - 1);
   localparam logic [c_cnt_w-1:0] c_load_1x1 = c_cnt_w'(CONFIG_BEATS_1X1_1 - 1);

   typedef enum logic [1:0] {
      CFG_1_S = 2'd0,
      CFG_2_S = 2'd1,
      PASS_S  = 2'd2
   } state_t;

   state_t                       r_state, w_state_nxt;
   logic [c_cnt_w-1:0]           r_count, w_count_nxt;
   logic                         r_is3, w_is3_nxt;
   logic                         w_err_set;
   logic                         w_push, w_pop;
   logic [c_beat_w-1:0]          w_push_beat;
   logic [TUSER_WIDTH_LRELU-1:0] w_cfg_user;

   logic                         r_in_ready;
   logic [1:0]                   r_occ, w_occ_nxt;
   logic                         r_wr_ptr, r_rd_ptr;
   logic [c_beat_w-1:0]          r_mem [2];

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_is3_nxt    = r_is3;
      w_err_set    = 1'b0;
      w_push       = 1'b0;
      w_push_beat  = '0;
      w_cfg_user   = '0;
      s_cfg.tready  = 1'b0;
      s_data.tready = 1'b0;
      case (r_state)
         CFG_1_S: begin
            s_cfg.tready         = r_in_ready;
            w_cfg_user[I_IS_3X3] = s_cfg.tuser[0];
            w_push_beat          = {s_cfg.tdata, w_cfg_user, 1'b0};
            if (s_cfg.tvalid && r_in_ready) begin
               w_push      = 1'b1;
               w_is3_nxt   = s_cfg.tuser[0];
               w_count_nxt = s_cfg.tuser[0] ? c_load_3x3 : c_load_1x1;
               w_err_set   = s_cfg.tlast;
               w_state_nxt = CFG_2_S;
            end
         end
         CFG_2_S: begin
            s_cfg.tready         = r_in_ready;
            w_cfg_user[I_IS_3X3] = r_is3;
            w_push_beat          = {s_cfg.tdata, w_cfg_user, 1'b0};
            if (s_cfg.tvalid && r_in_ready) begin
               w_push    = 1'b1;
               w_err_set = (s_cfg.tlast != (r_count == '0));
               if (r_count == '0) begin
                  w_state_nxt = PASS_S;
               end else begin
                  w_count_nxt = r_count - c_one;
               end
            end
         end
         PASS_S: begin
            s_data.tready = r_in_ready;
            w_push_beat   = {s_data.tdata, s_data.tuser, s_data.tlast};
            if (s_data.tvalid && r_in_ready) begin
               w_push = 1'b1;
               if (s_data.tlast) begin
                  w_state_nxt = CFG_1_S;
               end
            end
         end
         default: begin
            w_state_nxt = CFG_1_S;
         end
      endcase
   end

   // Two-entry output queue; ready is registered so it never sees m_axis.tready.
   assign w_pop     = (r_occ != 2'd0) && m_axis.tready;
   assign w_occ_nxt = r_occ + 2'(w_push) - 2'(w_pop);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= CFG_1_S;
         r_count    <= '0;
         r_is3      <= 1'b0;
         cfg_err    <= 1'b0;
         r_in_ready <= 1'b0;
         r_occ      <= 2'd0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_is3      <= w_is3_nxt;
         r_in_ready <= (w_occ_nxt != 2'd2);
         r_occ      <= w_occ_nxt;
         if (w_err_set) cfg_err  <= 1'b1;
         if (w_push)    r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)     r_rd_ptr <= ~r_rd_ptr;
      end
   end

   always_ff @(posedge aclk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_beat;
      end
   end

   assign m_axis.tvalid = (r_occ != 2'd0);
   assign {m_axis.tdata, m_axis.tuser, m_axis.tlast} = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_axis_lrelu_frame_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_lrelu_frame_builder
// Brief    : Directed self-checking bench for axis_lrelu_frame_builder
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_lrelu_frame_builder;
   localparam int DATA_W   = 2*2*2*8*32;
   localparam int TUSER_W  = 3 + 8;
   localparam int I_IS_3X3 = 3;

   typedef struct packed {
      logic [DATA_W-1:0]  d;
      logic [TUSER_W-1:0] u;
      logic               l;
   } beat_t;

   logic  aclk    = 1'b0;
   logic  aresetn = 1'b0;
   logic  cfg_err;
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_out    = 0;
   bit    bp_mode  = 1'b0;
   bit    lat_chk  = 1'b0;
   bit    prev_stall = 1'b0;
   beat_t exp_q[$];
   beat_t cur, prev, e_beat;

   always #5 aclk = ~aclk;

   axis_lrelu_frame_builder_if #(.DATA_W(DATA_W), .USER_W(1))       cfg_if  ();
   axis_lrelu_frame_builder_if #(.DATA_W(DATA_W), .USER_W(TUSER_W)) data_if ();
   axis_lrelu_frame_builder_if #(.DATA_W(DATA_W), .USER_W(TUSER_W)) m_if    ();

   axis_lrelu_frame_builder u_dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_cfg   (cfg_if),
      .s_data  (data_if),
      .m_axis  (m_if),
      .cfg_err (cfg_err)
   );

   assign cur = {m_if.tdata, m_if.tuser, m_if.tlast};

   always @(posedge aclk) begin
      #1;
      m_if.tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Scoreboard and stall-stability monitor
   always @(negedge aclk) begin
      if (aresetn !== 1'b1) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_checks++;
            assert (m_if.tvalid === 1'b1 && cur === prev) else begin
               n_fail++;
               $error("FAIL stall_hold: observed valid=%b data=%h user=%h last=%b, required valid=1 data=%h user=%h last=%b",
                      m_if.tvalid, cur.d[63:0], cur.u, cur.l, prev.d[63:0], prev.u, prev.l);
            end
         end
         if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL extra_beat: observed output beat %0d data=%h, required no beat", n_out, cur.d[63:0]);
            end
            if (exp_q.size() != 0) begin
               e_beat = exp_q.pop_front();
               n_checks++;
               assert (cur === e_beat) else begin
                  n_fail++;
                  $error("FAIL beat_%0d: observed data=%h user=%h last=%b, required data=%h user=%h last=%b",
                         n_out, cur.d[63:0], cur.u, cur.l, e_beat.d[63:0], e_beat.u, e_beat.l);
               end
            end
            n_out++;
         end
         prev_stall = (m_if.tvalid === 1'b1 && m_if.tready === 1'b0);
         prev       = cur;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, required %h", tag, obs, exp);
      end
   endtask

   task automatic send_cfg(input logic [31:0] w, input logic is3_pin, input logic last,
                           input logic exp_is3);
      bit    ok;
      beat_t b;
      cfg_if.tdata  = {64{w}};
      cfg_if.tuser  = is3_pin;
      cfg_if.tlast  = last;
      cfg_if.tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge aclk);
         if (data_if.tvalid === 1'b1) check("data_held_in_hdr", 64'(data_if.tready), 64'd0);
         if (cfg_if.tready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge aclk);
      #1;
      cfg_if.tvalid = 1'b0;
      check("cfg_accept", 64'(ok), 64'd1);
      b.d = {64{w}};
      b.u = '0;
      b.u[I_IS_3X3] = exp_is3;
      b.l = 1'b0;
      if (ok) exp_q.push_back(b);
      if (lat_chk) check("lat_cfg", {31'd0, m_if.tvalid, m_if.tdata[31:0]}, {32'd1, w});
   endtask

   task automatic send_data(input logic [31:0] w, input logic [TUSER_W-1:0] u, input logic last);
      bit    ok;
      beat_t b;
      data_if.tdata  = {64{w}};
      data_if.tuser  = u;
      data_if.tlast  = last;
      data_if.tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge aclk);
         if (data_if.tready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge aclk);
      #1;
      data_if.tvalid = 1'b0;
      check("data_accept", 64'(ok), 64'd1);
      b.d = {64{w}};
      b.u = u;
      b.l = last;
      if (ok) exp_q.push_back(b);
      if (lat_chk) check("lat_data", {31'd0, m_if.tvalid, m_if.tdata[31:0]}, {32'd1, w});
   endtask

   // is_3x3 only counts on the first beat; later beats drive the opposite value.
   task automatic send_header(input logic is3, input int n);
      for (int i = 0; i < n; i++) begin
         send_cfg($urandom, (i == 0) ? is3 : ~is3, (i == n - 1), is3);
      end
   endtask

   task automatic send_layer(input int n);
      for (int i = 0; i < n; i++) begin
         send_data($urandom, TUSER_W'($urandom), (i == n - 1));
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 500; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge aclk);
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      @(posedge aclk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      check("rst_cfg_err", 64'(cfg_err), 64'd0);
      exp_q.delete();
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
   endtask

   initial begin
      cfg_if.tvalid  = 1'b0; cfg_if.tdata  = '0; cfg_if.tuser  = '0; cfg_if.tlast  = 1'b0;
      data_if.tvalid = 1'b0; data_if.tdata = '0; data_if.tuser = '0; data_if.tlast = 1'b0;

      repeat (3) @(posedge aclk);
      #1;
      check("rst_cfg_ready",  64'(cfg_if.tready),  64'd0);
      check("rst_data_ready", 64'(data_if.tready), 64'd0);
      check("rst_m_valid",    64'(m_if.tvalid),    64'd0);
      check("rst_err",        64'(cfg_err),        64'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      check("rel_cfg_ready",  64'(cfg_if.tready),  64'd1);
      check("rel_data_ready", 64'(data_if.tready), 64'd0);

      // 3x3 frame followed back-to-back by a 1x1 frame
      lat_chk = 1'b1;
      send_header(1'b1, 20);
      send_layer(4);
      check("cfg_ready_after_tlast", 64'(cfg_if.tready), 64'd1);
      send_header(1'b0, 9);
      send_layer(2);
      check("err_clean", 64'(cfg_err), 64'd0);

      // Data valid held across a whole 3x3 header
      data_if.tdata  = {64{32'hDA7A0001}};
      data_if.tuser  = 11'h5A5;
      data_if.tlast  = 1'b0;
      data_if.tvalid = 1'b1;
      send_header(1'b1, 20);
      check("data_ready_after_hdr", 64'(data_if.tready), 64'd1);
      check("cfg_ready_in_pass",    64'(cfg_if.tready),  64'd0);
      send_data(32'hDA7A0001, 11'h5A5, 1'b0);
      send_data(32'hDA7A0002, 11'h0F3, 1'b1);

      // Random backpressure over mixed frames, including a one-beat layer
      lat_chk = 1'b0;
      bp_mode = 1'b1;
      send_header(1'b0, 9);  send_layer(3);
      send_header(1'b1, 20); send_layer(1);
      send_header(1'b1, 20); send_layer(2);
      send_header(1'b0, 9);  send_layer(1);
      send_header(1'b0, 9);  send_layer(3);
      drain();
      bp_mode = 1'b0;
      drain();
      check("err_after_bp", 64'(cfg_err), 64'd0);

      // Early tlast on beat 5 of a 1x1 header
      for (int i = 0; i < 9; i++) begin
         send_cfg($urandom, 1'b0, (i == 4) || (i == 8), 1'b0);
         if (i == 3) check("err1_before", 64'(cfg_err), 64'd0);
         if (i == 4) check("err1_set",    64'(cfg_err), 64'd1);
      end
      check("err1_sticky",  64'(cfg_err),        64'd1);
      check("err1_hdr_len", 64'(data_if.tready), 64'd1);
      send_layer(1);
      check("err1_sticky_pass", 64'(cfg_err), 64'd1);
      drain();
      apply_reset();

      // Missing tlast on the final beat of a 1x1 header
      for (int i = 0; i < 9; i++) begin
         send_cfg($urandom, 1'b0, 1'b0, 1'b0);
         if (i == 7) check("err2_before", 64'(cfg_err), 64'd0);
      end
      check("err2_set", 64'(cfg_err), 64'd1);
      send_layer(1);
      drain();
      apply_reset();

      // Reset during beat 10 of a 3x3 header
      for (int i = 0; i < 9; i++) begin
         send_cfg($urandom, (i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1);
      end
      cfg_if.tdata  = {64{32'hBAD0000A}};
      cfg_if.tvalid = 1'b1;
      #2;
      aresetn = 1'b0;
      #1;
      check("midrst_m_valid",   64'(m_if.tvalid),   64'd0);
      check("midrst_cfg_ready", 64'(cfg_if.tready), 64'd0);
      cfg_if.tvalid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      check("midrst_rel_cfg_ready",  64'(cfg_if.tready),  64'd1);
      check("midrst_rel_data_ready", 64'(data_if.tready), 64'd0);
      check("midrst_err",            64'(cfg_err),        64'd0);
      send_header(1'b0, 9);
      send_layer(2);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
